text_rx_sink: RTL and testbench
===============================

Name: text_rx_sink

Overview:
- Receive-side stage that consumes the decrypted 8-bit character stream leaving the decrypt stage.
- Buffers characters in a FIFO and tracks line terminators.
- Exposes a pop-style read interface and status counters to the sink / host logic.
- Decouples the one-byte-per-cycle decrypt output from a slower consumer.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of two, minimum 4.
- TERM, 8'h0A, line terminator character.
- CNT_W, 16, width of char_count and line_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- data_in  input  8  decrypted character from the decrypt stage.
- data_valid  input  1  data_in qualifier; one byte per cycle when high.
- rd_en  input  1  consumer pop request.
- rd_data  output  8  popped byte, registered.
- rd_valid  output  1  high for one cycle when rd_data holds a byte popped the previous cycle.
- empty  output  1  FIFO holds zero bytes.
- full  output  1  FIFO holds DEPTH bytes.
- line_ready  output  1  at least one complete line (TERM) is buffered.
- char_count  output  CNT_W  bytes accepted into the FIFO since reset.
- line_count  output  CNT_W  TERM bytes accepted since reset.
- overflow  output  1  sticky; a valid byte was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, async): all pointers and counters = 0, occupancy = 0.
  - Output reset values: rd_data=8'h00, rd_valid=0, empty=1, full=0, line_ready=0, char_count=0, line_count=0, overflow=0.
  - Reset mid-operation discards buffered data immediately; deassertion is synchronised by the usual two-flop reset release.
- Storage: circular buffer, DEPTH entries.
  - Write and read pointers are log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - full = (ptr MSBs differ and lower bits equal); empty = (pointers equal).
- Write accept: data_valid=1 AND (full=0 OR pop this cycle).
  - Accepted byte is stored at the write pointer, the pointer increments, char_count increments.
  - If the byte == TERM, line_count also increments.
- Drop: data_valid=1 AND full=1 AND no pop this cycle → byte discarded; overflow <= 1 and stays set until reset. Counters are not incremented.
- Pop: rd_en=1 AND empty=0.
  - rd_data <= entry at the read pointer; read pointer increments; rd_valid=1 the next cycle.
  - rd_en while empty is ignored: rd_valid=0, rd_data holds its last value.
- Read latency: 1 cycle from rd_en to rd_valid/rd_data.
- Simultaneous pop and write:
  - Occupancy is unchanged; both take effect in the same cycle.
  - When full, the write is accepted (the pop frees a slot).
  - When empty, the pop is ignored and only the write occurs; no read-through.
- Terminator tracking: term_pending counter, width log2(DEPTH)+1.
  - +1 when an accepted byte == TERM; −1 when a popped byte == TERM; both in the same cycle → unchanged.
  - line_ready = (term_pending != 0), registered with the flags.
- Counters wrap modulo 2^CNT_W with no saturation.
- All status flags are registered and reflect state after the current edge.

Optional Feature:
- Macro: TEXT_RX_FILTER_EN.
- Defined: a byte is accepted only if it is printable ASCII (8'h20–8'h7E) or == TERM.
  - Rejected bytes are neither written nor counted and never set overflow.
  - Each rejected byte increments an added output port reject_count [CNT_W-1:0] (reset 0, wraps).
- Not defined: every valid byte is accepted subject only to full; port reject_count does not exist.

Test Plan:
- Reset/basic pass-through: reset=0 for 3 cycles, then push "HI\n" (48,49,0A) → empty=0 after first write, char_count=3, line_count=1, line_ready=1. Three pops return 48,49,0A with rd_valid one cycle after each rd_en. After the final pop: empty=1, line_ready=0.
- Full/overflow: DEPTH=16, push 17 bytes 8'h41 with no reads → full=1 after the 16th, 17th byte dropped, overflow=1, char_count=16. One pop clears full; overflow stays 1.
- Simultaneous at full: full FIFO, rd_en=1 and data_valid=1 with 8'h5A in the same cycle → occupancy stays 16, full=1. rd_data is the oldest byte; 8'h5A is read out 16 pops later.
- Empty pop: empty FIFO, rd_en=1 for 4 cycles → rd_valid stays 0, pointers unchanged, rd_data unchanged.
- Async reset mid-stream: 5 bytes buffered, assert reset between clock edges → empty=1, counters=0, overflow=0 before the next edge. A write after release is stored at slot 0 and read back correctly.
- Filter (TEXT_RX_FILTER_EN defined): push 8'h07, 8'h41, 8'h0A, 8'hFF → char_count=2, line_count=1, reject_count=2. Pops return 41, 0A.

Source files
------------

// File: rtl/text_rx_sink.sv
// text_rx_sink: byte FIFO sink for the decrypted stream with line tracking and status counters.
// Define TEXT_RX_FILTER_EN to accept only printable ASCII or TERM, counting rejects on reject_count.
module text_rx_sink #(
  parameter int          DEPTH = 16,
  parameter logic [7:0]  TERM  = 8'h0A,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic             line_ready,
  output logic [CNT_W-1:0] char_count,
  output logic [CNT_W-1:0] line_count,
  output logic             overflow
`ifdef TEXT_RX_FILTER_EN
  ,
  output logic [CNT_W-1:0] reject_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0]    rs;
  logic          rst_n;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, tp, wr_n, rd_n, tp_n;
  logic          pass, pop, acc, drop, term_in, term_out;
  // Reset asserts immediately and releases two edges later.
  always_ff @(posedge clk or negedge reset)
    if (!reset) rs <= 2'b00;
    else        rs <= {rs[0], 1'b1};
  assign rst_n = rs[1];
`ifdef TEXT_RX_FILTER_EN
  assign pass = (data_in >= 8'h20 && data_in <= 8'h7E) || data_in == TERM;
`else
  assign pass = 1'b1;
`endif
  always_comb begin
    pop      = rd_en && !empty;
    acc      = data_valid && pass && (!full || pop);
    drop     = data_valid && pass && full && !pop;
    term_in  = acc && data_in == TERM;
    term_out = pop && mem[rd_ptr[AW-1:0]] == TERM;
    wr_n     = wr_ptr + (AW+1)'(acc);
    rd_n     = rd_ptr + (AW+1)'(pop);
    tp_n     = tp + (AW+1)'(term_in) - (AW+1)'(term_out);
  end
  always_ff @(posedge clk)
    if (acc) mem[wr_ptr[AW-1:0]] <= data_in;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tp         <= '0;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      empty      <= 1'b1;
      full       <= 1'b0;
      line_ready <= 1'b0;
      char_count <= '0;
      line_count <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr     <= wr_n;
      rd_ptr     <= rd_n;
      tp         <= tp_n;
      rd_data    <= pop ? mem[rd_ptr[AW-1:0]] : rd_data;
      rd_valid   <= pop;
      empty      <= wr_n == rd_n;
      full       <= wr_n[AW] != rd_n[AW] && wr_n[AW-1:0] == rd_n[AW-1:0];
      line_ready <= tp_n != '0;
      char_count <= char_count + CNT_W'(acc);
      line_count <= line_count + CNT_W'(term_in);
      overflow   <= overflow | drop;
    end
`ifdef TEXT_RX_FILTER_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) reject_count <= '0;
    else        reject_count <= reject_count + CNT_W'(data_valid && !pass);
`endif
endmodule

// File: tb/tb_text_rx_sink.sv
// tb_text_rx_sink: randomized and directed checks of text_rx_sink against a queue-based model.
module tb_text_rx_sink;
  localparam int DEPTH = 16;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid, empty, full, line_ready, overflow;
  logic [15:0] char_count, line_count;
`ifdef TEXT_RX_FILTER_EN
  logic [15:0] reject_count;
`endif
  int checks = 0;
  int failures = 0;
  logic [7:0]  q[$];
  logic [15:0] m_cc, m_lc, m_rej;
  logic        m_ovf, m_rv;
  logic [7:0]  m_rd;

  text_rx_sink #(.DEPTH(DEPTH), .TERM(8'h0A), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full), .line_ready(line_ready),
    .char_count(char_count), .line_count(line_count), .overflow(overflow)
`ifdef TEXT_RX_FILTER_EN
    , .reject_count(reject_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit passes(input logic [7:0] d);
`ifdef TEXT_RX_FILTER_EN
    return (d >= 8'h20 && d <= 8'h7E) || d == 8'h0A;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int terms_buffered();
    int n = 0;
    foreach (q[i]) if (q[i] == 8'h0A) n++;
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cc = 0; m_lc = 0; m_rej = 0; m_ovf = 0; m_rv = 0; m_rd = 8'h00;
  endtask

  task automatic model(input logic dv, input logic [7:0] d, input logic re);
    bit pop, room;
    pop  = re && q.size() != 0;
    room = q.size() < DEPTH || pop;
    m_rv = pop;
    if (pop) m_rd = q.pop_front();
    if (dv && !passes(d)) m_rej++;
    else if (dv && room) begin
      q.push_back(d);
      m_cc++;
      if (d == 8'h0A) m_lc++;
    end else if (dv) m_ovf = 1'b1;
  endtask

  task automatic compare_all();
    check("rd_valid", rd_valid, m_rv);
    check("rd_data", rd_data, m_rd);
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == DEPTH);
    check("line_ready", line_ready, terms_buffered() != 0);
    check("char_count", char_count, m_cc);
    check("line_count", line_count, m_lc);
    check("overflow", overflow, m_ovf);
`ifdef TEXT_RX_FILTER_EN
    check("reject_count", reject_count, m_rej);
`endif
  endtask

  task automatic step(input logic dv, input logic [7:0] d, input logic re);
    data_valid = dv; data_in = d; rd_en = re;
    @(posedge clk);
    model(dv, d, re);
    #1 compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic async_reset();
    data_valid = 1'b0; rd_en = 1'b0;
    #2 reset = 1'b0;
    #1 model_reset();
    check("async_empty", empty, 1'b1);
    check("async_char_count", char_count, 0);
    compare_all();
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b1;
    idle(3);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_empty", empty, 1'b1);
    check("reset_rd_data", rd_data, 8'h00);
    compare_all();
    reset = 1'b1;
    idle(3);
    // pass-through "HI\n"
    step(1, 8'h48, 0);
    check("hi_empty_after_first", empty, 1'b0);
    step(1, 8'h49, 0);
    step(1, 8'h0A, 0);
    check("hi_char_count", char_count, 3);
    check("hi_line_count", line_count, 1);
    check("hi_line_ready", line_ready, 1'b1);
    step(0, 0, 1); check("hi_pop0", {rd_valid, rd_data}, 9'h148);
    step(0, 0, 1); check("hi_pop1", {rd_valid, rd_data}, 9'h149);
    step(0, 0, 1); check("hi_pop2", {rd_valid, rd_data}, 9'h10A);
    check("hi_final_empty", {empty, line_ready}, 2'b10);
    // empty pops
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    check("empty_pop_hold", {rd_valid, rd_data}, 9'h00A);
    // full and overflow
    async_reset();
    for (int i = 0; i < 17; i++) step(1, 8'h41, 0);
    check("ovf_full", {full, overflow}, 2'b11);
    check("ovf_char_count", char_count, 16);
    step(0, 0, 1);
    check("ovf_after_pop", {full, overflow}, 2'b01);
    step(1, 8'h41, 0);
    step(1, 8'h5A, 1);
    check("simul_full", {full, rd_valid, rd_data}, 10'h341);
    for (int i = 0; i < 16; i++) step(0, 0, 1);
    check("simul_last", {rd_valid, rd_data, empty}, 10'h2B5);
    // async reset mid-stream then slot 0 reuse
    for (int i = 0; i < 5; i++) step(1, 8'h30 + 8'(i), 0);
    async_reset();
    step(1, 8'h77, 0);
    step(0, 0, 1);
    check("post_reset_read", {rd_valid, rd_data}, 9'h177);
`ifdef TEXT_RX_FILTER_EN
    async_reset();
    step(1, 8'h07, 0); step(1, 8'h41, 0); step(1, 8'h0A, 0); step(1, 8'hFF, 0);
    check("filt_counts", {char_count, line_count, reject_count}, {16'd2, 16'd1, 16'd2});
    step(0, 0, 1); check("filt_pop0", rd_data, 8'h41);
    step(0, 0, 1); check("filt_pop1", rd_data, 8'h0A);
`endif
    // randomized phases: write-heavy, balanced, read-heavy
    for (int p = 0; p < 3; p++) begin
      int wp, rp;
      wp = (p == 0) ? 85 : (p == 1) ? 50 : 25;
      rp = (p == 0) ? 25 : (p == 1) ? 50 : 85;
      for (int i = 0; i < 700; i++) begin
        logic [7:0] d;
        d = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
        step($urandom_range(0, 99) < wp, d, $urandom_range(0, 99) < rp);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
